red_pitaya_ad5689_rx: RTL
=========================

# red_pitaya_ad5689_rx

SPI responder and register model for the AD5689 dual 16-bit DAC serial protocol. It samples externally supplied SCLK/SDIN/SYNC/LDAC/RESET lines, oversampled by the 125 MHz fabric clock. It decodes 24-bit command frames into per-channel input and DAC registers, and publishes the DAC register values as parallel outputs and on the system bus. It serves as the loopback/monitor end of the slow-DAC link: it checks transmitted frames in-system and emulates the DAC in simulation.

## Interface

- No parameters; frame length fixed at 24 bits, sclk ≤ 31.25 MHz (≥ 2 clk_i high and 2 low).
- clk_i  in  1  125 MHz clock
- rstn_i  in  1  reset; one clock; reset is asynchronous and active-low
- spi_sclk_i  in  1  serial clock, asynchronous to clk_i
- spi_sdin_i  in  1  serial data, MSB first
- spi_syncn_i  in  1  frame select, active low
- spi_ldacn_i  in  1  load-DAC strobe, active low
- spi_rstn_i  in  1  device reset pin, active low
- dac_a_o  out  16  DAC register A
- dac_b_o  out  16  DAC register B
- dac_upd_o  out  1  one-cycle pulse when either DAC register changes
- sys_addr  in  32  bus address
- sys_wdata  in  32  bus write data
- sys_sel  in  4  byte select (ignored)
- sys_wen  in  1  bus write enable
- sys_ren  in  1  bus read enable
- sys_rdata  out  32  bus read data
- sys_err  out  1  always 0
- sys_ack  out  1  bus acknowledge

## Operation

- All five SPI inputs pass through 2-FF synchronizers plus one history FF for edge detection. Reset value of the synchronizers is 1 for syncn/ldacn/rstn and 0 for sclk/sdin.
- FSM states:
  - IDLE: syncn falling edge -> SHIFT, bit counter = 0, shift register = 0.
  - SHIFT: each sclk falling edge shifts sdin into the LSB and increments the counter. On the 24th edge -> EXEC.
    - syncn rises before 24 edges -> ABORT.
  - EXEC (1 cycle): decode {cmd[23:20], addr[19:16], data[15:0]}, increment frame_cnt, store last_word -> WAIT.
  - WAIT: ignore further sclk edges; on the first extra edge set overrun, increment err_cnt once. syncn rising -> IDLE.
  - ABORT (1 cycle): increment err_cnt, no register change -> IDLE.
- Address decode: addr[0] selects A, addr[3] selects B; both may be set (0x9). Other address bits are ignored.
- Commands:
  - 0x1: write input register(s). If ldacn is synchronized-low at EXEC, also copy to the DAC register of each unmasked selected channel.
  - 0x2: copy input -> DAC for selected channels, ignoring the mask.
  - 0x3: write input and DAC registers of selected channels.
  - 0x5: software reset, same as the spi_rstn_i effect.
  - 0x6: ldac_mask <= data[1:0], bit0 = A, bit1 = B.
  - Any other command: counted in frame_cnt, no other effect.
- ldacn falling edge (synchronized): copy input -> DAC for every channel whose mask bit is 0.
- Simultaneous EXEC and ldacn falling edge in the same cycle: the frame write is applied first, so the new input value reaches the DAC register.
- spi_rstn_i synchronized low (level): clear input, DAC, mask and overrun; FSM -> IDLE. A frame in progress is dropped without incrementing err_cnt. Counters are preserved.
- dac_upd_o pulses when any DAC register write occurs, even if the value is unchanged.
- Counters: frame_cnt and err_cnt are 16 bits each and wrap at 0xFFFF -> 0.
- Register map, sys_addr[19:0]:
  - 0x00: dac_a
  - 0x04: dac_b
  - 0x08: input_a
  - 0x0C: input_b
  - 0x10: {err_cnt, frame_cnt}
  - 0x14: {5'b0, overrun, ldac_mask, last_word}
  - 0x18: write any value to clear both counters and overrun; reads 0
  - Other addresses read 0; writes to read-only addresses are ignored.

## Timing

- Reset (rstn_i low): all registers, counters and outputs are 0; sys_err = 0, sys_ack = 0; FSM in IDLE.
- Pin edge to detected edge: 3 clk_i cycles.
- 24th sclk falling edge to EXEC: 3 cycles. EXEC to updated dac_x_o and dac_upd_o high: 1 cycle, so 4 cycles end to end.
- ldacn falling edge at the pin to dac_x_o: 4 cycles.
- sys_ack = sys_wen | sys_ren registered, i.e. 1 cycle after the request. sys_rdata is valid in the same cycle as sys_ack.
- A counter clear on the bus in the same cycle as an increment wins: the counter reads 0.

## Test plan

- Frame 0x11_1234, then ldacn low for 8 cycles -> input_a = 0x1234; dac_a_o = 0 until 4 cycles after the ldacn fall, then 0x1234 with one dac_upd_o pulse.
- Frame 0x39_BEEF -> dac_a_o = dac_b_o = 0xBEEF 4 cycles after the 24th edge; frame_cnt = 1.
- Frame 0x60_0002, then 0x19_5555, then an ldacn pulse -> dac_a_o = 0x5555, dac_b_o unchanged; a following 0x28_0000 -> dac_b_o = 0x5555.
- 20-bit frame (syncn rises early) -> no register change, err_cnt = 1. A 26-bit frame of 0x18_00AA -> input_b = 0x00AA, overrun = 1, err_cnt = 2.
- spi_rstn_i low for 4 cycles mid-frame after dac_a = 0x1234 -> all DAC and input registers = 0, FSM idle, err_cnt unchanged; the next complete frame decodes correctly.
- Bus: read 0x10 after 3 good frames -> 0x0000_0003 with sys_ack 1 cycle after sys_ren; write 0x18 -> read 0x10 returns 0.

Source files
------------

// File: rtl/red_pitaya_ad5689_rx.sv
// AD5689 serial-link responder: decodes 24-bit frames into
// input/DAC registers and exposes them on the system bus.
module red_pitaya_ad5689_rx (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        spi_sclk_i,
  input  logic        spi_sdin_i,
  input  logic        spi_syncn_i,
  input  logic        spi_ldacn_i,
  input  logic        spi_rstn_i,
  output logic [15:0] dac_a_o,
  output logic [15:0] dac_b_o,
  output logic        dac_upd_o,
  input  logic [31:0] sys_addr,
  input  logic [31:0] sys_wdata,
  input  logic [3:0]  sys_sel,
  input  logic        sys_wen,
  input  logic        sys_ren,
  output logic [31:0] sys_rdata,
  output logic        sys_err,
  output logic        sys_ack
);

  typedef enum logic [2:0] {
    IDLE, SHIFT, EXEC, WAIT, ABORT
  } state_t;

  state_t      state;
  logic [2:0]  sclk_q, sdin_q, sync_q, ldac_q, rst_q;
  logic [4:0]  cnt;
  logic [23:0] sr, last_word;
  logic [15:0] in_a, in_b, frame_cnt, err_cnt;
  logic [1:0]  mask;
  logic        overrun, extra, ldac_p;

  logic        sclk_fall, sync_fall, sync_rise, ldac_fall;
  logic        spi_rst, ldac_low, clr;
  logic [15:0] in_a_n, in_b_n, dac_a_n, dac_b_n, data;
  logic [1:0]  mask_n;
  logic        wr_a, wr_b, swrst, sel_a, sel_b;
  logic        unused;

  assign unused = ^{sys_sel, sys_wdata, sys_addr[31:20],
                    sdin_q[2], rst_q[2]};

  // bit 1 is the synchronized level, bit 2 the history
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sclk_q <= 3'b000;
      sdin_q <= 3'b000;
      sync_q <= 3'b111;
      ldac_q <= 3'b111;
      rst_q  <= 3'b111;
    end else begin
      sclk_q <= {sclk_q[1:0], spi_sclk_i};
      sdin_q <= {sdin_q[1:0], spi_sdin_i};
      sync_q <= {sync_q[1:0], spi_syncn_i};
      ldac_q <= {ldac_q[1:0], spi_ldacn_i};
      rst_q  <= {rst_q[1:0], spi_rstn_i};
    end
  end

  assign sclk_fall = sclk_q[2] & ~sclk_q[1];
  assign sync_fall = sync_q[2] & ~sync_q[1];
  assign sync_rise = ~sync_q[2] & sync_q[1];
  assign ldac_fall = ldac_q[2] & ~ldac_q[1];
  assign ldac_low  = ~ldac_q[1];
  assign spi_rst   = ~rst_q[1];
  assign clr       = sys_wen && (sys_addr[19:0] == 20'h18);
  assign data      = sr[15:0];
  assign sel_a     = sr[16];
  assign sel_b     = sr[19];

  // frame write first, then the LDAC copy sees the new input value
  always_comb begin
    in_a_n  = in_a;
    in_b_n  = in_b;
    dac_a_n = dac_a_o;
    dac_b_n = dac_b_o;
    mask_n  = mask;
    wr_a    = 1'b0;
    wr_b    = 1'b0;
    swrst   = 1'b0;
    if (state == EXEC) begin
      unique case (sr[23:20])
        4'h1: begin
          if (sel_a) in_a_n = data;
          if (sel_b) in_b_n = data;
          if (ldac_low && sel_a && !mask[0]) begin
            dac_a_n = data;
            wr_a    = 1'b1;
          end
          if (ldac_low && sel_b && !mask[1]) begin
            dac_b_n = data;
            wr_b    = 1'b1;
          end
        end
        4'h2: begin
          if (sel_a) begin
            dac_a_n = in_a;
            wr_a    = 1'b1;
          end
          if (sel_b) begin
            dac_b_n = in_b;
            wr_b    = 1'b1;
          end
        end
        4'h3: begin
          if (sel_a) begin
            in_a_n  = data;
            dac_a_n = data;
            wr_a    = 1'b1;
          end
          if (sel_b) begin
            in_b_n  = data;
            dac_b_n = data;
            wr_b    = 1'b1;
          end
        end
        4'h5: swrst = 1'b1;
        4'h6: mask_n = data[1:0];
        default: ;
      endcase
    end
    if (ldac_p && !mask[0]) begin
      dac_a_n = in_a_n;
      wr_a    = 1'b1;
    end
    if (ldac_p && !mask[1]) begin
      dac_b_n = in_b_n;
      wr_b    = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= IDLE;
      cnt       <= 5'd0;
      sr        <= 24'd0;
      last_word <= 24'd0;
      in_a      <= 16'd0;
      in_b      <= 16'd0;
      dac_a_o   <= 16'd0;
      dac_b_o   <= 16'd0;
      dac_upd_o <= 1'b0;
      mask      <= 2'b00;
      overrun   <= 1'b0;
      extra     <= 1'b0;
      ldac_p    <= 1'b0;
      frame_cnt <= 16'd0;
      err_cnt   <= 16'd0;
    end else begin
      ldac_p <= ldac_fall;
      unique case (state)
        IDLE: if (sync_fall) begin
          state <= SHIFT;
          cnt   <= 5'd0;
          sr    <= 24'd0;
        end
        SHIFT: begin
          if (sclk_fall && cnt == 5'd23) begin
            sr    <= {sr[22:0], sdin_q[1]};
            state <= EXEC;
          end else if (sync_rise) begin
            state <= ABORT;
          end else if (sclk_fall) begin
            sr  <= {sr[22:0], sdin_q[1]};
            cnt <= cnt + 5'd1;
          end
        end
        EXEC: begin
          frame_cnt <= frame_cnt + 16'd1;
          last_word <= sr;
          extra     <= 1'b0;
          state     <= WAIT;
        end
        WAIT: begin
          if (sclk_fall && !extra) begin
            extra   <= 1'b1;
            overrun <= 1'b1;
            err_cnt <= err_cnt + 16'd1;
          end
          if (sync_rise) state <= IDLE;
        end
        ABORT: begin
          err_cnt <= err_cnt + 16'd1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (spi_rst || swrst) begin
        in_a      <= 16'd0;
        in_b      <= 16'd0;
        dac_a_o   <= 16'd0;
        dac_b_o   <= 16'd0;
        mask      <= 2'b00;
        overrun   <= 1'b0;
        dac_upd_o <= 1'b0;
        state     <= IDLE;
      end else begin
        in_a      <= in_a_n;
        in_b      <= in_b_n;
        dac_a_o   <= dac_a_n;
        dac_b_o   <= dac_b_n;
        mask      <= mask_n;
        dac_upd_o <= wr_a | wr_b;
      end
      if (clr) begin
        frame_cnt <= 16'd0;
        err_cnt   <= 16'd0;
        overrun   <= 1'b0;
      end
    end
  end

  assign sys_err = 1'b0;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sys_ack   <= 1'b0;
      sys_rdata <= 32'd0;
    end else begin
      sys_ack <= sys_wen | sys_ren;
      unique case (sys_addr[19:0])
        20'h00:  sys_rdata <= {16'd0, dac_a_o};
        20'h04:  sys_rdata <= {16'd0, dac_b_o};
        20'h08:  sys_rdata <= {16'd0, in_a};
        20'h0C:  sys_rdata <= {16'd0, in_b};
        20'h10:  sys_rdata <= {err_cnt, frame_cnt};
        20'h14:  sys_rdata <= {5'd0, overrun, mask, last_word};
        default: sys_rdata <= 32'd0;
      endcase
    end
  end

endmodule
